// File: rtl/cpu_single_cycle.sv
// Single-cycle 16-bit RISC core: fetch, execute and retire one instruction per clock.
// The core holds the pc, the 16x16 register file, the Z/V/N flags and two byte-addressed memories.

module memory1c #(
  parameter int    DEPTH     = 65536,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);
  localparam int AW = $clog2(DEPTH) - 1;

  logic [15:0] mem [0:(DEPTH/2)-1];
  logic        unused_addr_lsb;

  assign unused_addr_lsb = addr[0];
  assign data_out = (enable && !wr) ? mem[addr[AW:1]] : 16'h0000;

  // synchronous word write
  always_ff @(posedge clk) begin
    if (enable && wr) begin
      mem[addr[AW:1]] <= data_in;
    end
  end
endmodule

module cpu_single_cycle #(
  parameter string IMEM_FILE = "instructions.img",
  parameter int    MEM_DEPTH = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic        hlt
);
  logic [15:0] instruction;
  logic [3:0]  opcode, rd, rs, rt;
  logic [15:0] regs [0:15];
  logic [15:0] rs_val, rt_val, rd_val;
  logic        z_flag, v_flag, n_flag;
  logic [15:0] pc_plus2, pc_next, br_off, mem_addr, mem_rdata, alu_out;
  logic        sat, z_we, nv_we, reg_write, mem_en, mem_wr;
  logic [3:0]  dest_reg;
  logic [15:0] reg_write_data;

  function automatic logic [16:0] sat_addsub(input logic [15:0] a, input logic [15:0] b,
                                             input logic sub);
    logic [15:0] bb, sum;
    bb  = sub ? ~b : b;
    sum = a + bb + {15'd0, sub};
    if ((a[15] == bb[15]) && (sum[15] != a[15])) begin
      return {1'b1, a[15] ? 16'h8000 : 16'h7FFF};
    end else begin
      return {1'b0, sum};
    end
  endfunction

  function automatic logic [15:0] paddsb(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  s;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = a[4*i +: 4] + b[4*i +: 4];
      if ((a[4*i+3] == b[4*i+3]) && (s[3] != a[4*i+3])) begin
        r[4*i +: 4] = a[4*i+3] ? 4'h8 : 4'h7;
      end else begin
        r[4*i +: 4] = s;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] red(input logic [15:0] a, input logic [15:0] b);
    return {{8{a[15]}}, a[15:8]} + {{8{b[15]}}, b[15:8]}
         + {{8{a[7]}}, a[7:0]} + {{8{b[7]}}, b[7:0]};
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] a, input logic [3:0] s);
    logic [31:0] t;
    t = {a, a} >> s;
    return t[15:0];
  endfunction

  function automatic logic cond_met(input logic [2:0] c, input logic z, input logic v,
                                    input logic n);
    case (c)
      3'b000:  return !z;
      3'b001:  return z;
      3'b010:  return !z && !n;
      3'b011:  return n;
      3'b100:  return z || !n;
      3'b101:  return n || z;
      3'b110:  return v;
      default: return 1'b1;
    endcase
  endfunction

  assign opcode = instruction[15:12];
  assign rd     = instruction[11:8];
  assign rs     = instruction[7:4];
  assign rt     = instruction[3:0];
  assign rs_val = (rs == 4'd0) ? 16'h0000 : regs[rs];
  assign rt_val = (rt == 4'd0) ? 16'h0000 : regs[rt];
  assign rd_val = (rd == 4'd0) ? 16'h0000 : regs[rd];

  assign pc_plus2 = pc + 16'd2;
  assign br_off   = {{6{instruction[8]}}, instruction[8:0], 1'b0};
  assign mem_addr = (rs_val & 16'hFFFE) + {{11{instruction[3]}}, instruction[3:0], 1'b0};
  assign mem_en   = (opcode == 4'h8) || (opcode == 4'h9);
  // a store still pending when reset rises must not reach memory
  assign mem_wr   = (opcode == 4'h9) && !rst_n;
  assign hlt      = (opcode == 4'hF);
  assign dest_reg = rd;

  memory1c #(.DEPTH(MEM_DEPTH), .INIT_FILE(IMEM_FILE)) memory1c_instr_instance (
    .clk(clk), .enable(1'b1), .wr(1'b0), .addr(pc), .data_in(16'h0000),
    .data_out(instruction)
  );

  memory1c #(.DEPTH(MEM_DEPTH), .INIT_FILE("")) memory1c_data_instance (
    .clk(clk), .enable(mem_en), .wr(mem_wr), .addr(mem_addr), .data_in(rd_val),
    .data_out(mem_rdata)
  );

  // decode and execute the current instruction
  always_comb begin
    alu_out        = 16'h0000;
    sat            = 1'b0;
    z_we           = 1'b0;
    nv_we          = 1'b0;
    reg_write      = 1'b0;
    reg_write_data = 16'h0000;
    pc_next        = pc_plus2;
    case (opcode)
      4'h0, 4'h1: begin
        {sat, alu_out} = sat_addsub(rs_val, rt_val, opcode[0]);
        z_we = 1'b1; nv_we = 1'b1; reg_write = 1'b1; reg_write_data = alu_out;
      end
      4'h2: begin alu_out = rs_val ^ rt_val; z_we = 1'b1; reg_write = 1'b1; reg_write_data = alu_out; end
      4'h3: begin reg_write = 1'b1; reg_write_data = red(rs_val, rt_val); end
      4'h4: begin alu_out = rs_val << rt; z_we = 1'b1; reg_write = 1'b1; reg_write_data = alu_out; end
      4'h5: begin
        alu_out = 16'($signed(rs_val) >>> rt);
        z_we = 1'b1; reg_write = 1'b1; reg_write_data = alu_out;
      end
      4'h6: begin alu_out = ror(rs_val, rt); z_we = 1'b1; reg_write = 1'b1; reg_write_data = alu_out; end
      4'h7: begin reg_write = 1'b1; reg_write_data = paddsb(rs_val, rt_val); end
      4'h8: begin reg_write = 1'b1; reg_write_data = mem_rdata; end
      4'h9: begin reg_write = 1'b0; end
      4'hA: begin reg_write = 1'b1; reg_write_data = (rd_val & 16'hFF00) | {8'h00, instruction[7:0]}; end
      4'hB: begin reg_write = 1'b1; reg_write_data = (rd_val & 16'h00FF) | {instruction[7:0], 8'h00}; end
      4'hC: begin
        if (cond_met(instruction[11:9], z_flag, v_flag, n_flag)) begin
          pc_next = pc_plus2 + br_off;
        end else begin
          pc_next = pc_plus2;
        end
      end
      4'hD: begin
        if (cond_met(instruction[11:9], z_flag, v_flag, n_flag)) begin
          pc_next = rs_val;
        end else begin
          pc_next = pc_plus2;
        end
      end
      4'hE: begin reg_write = 1'b1; reg_write_data = pc_plus2; end
      default: begin pc_next = pc; end
    endcase
  end

  // architectural state: pc, register file, flags
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc     <= 16'h0000;
      z_flag <= 1'b0;
      v_flag <= 1'b0;
      n_flag <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      pc <= pc_next;
      if (reg_write && (dest_reg != 4'd0)) begin
        regs[dest_reg] <= reg_write_data;
      end
      if (z_we) begin
        z_flag <= (alu_out == 16'h0000);
      end
      if (nv_we) begin
        v_flag <= sat;
        n_flag <= alu_out[15];
      end
    end
  end
endmodule

// File: tb/tb_cpu_single_cycle.sv
// Directed bench for cpu_single_cycle: programs are written into instruction memory while the
// expected per-cycle retirement record is queued, then each cycle pops and compares.

module tb_cpu_single_cycle;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pc;
  logic        hlt;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        hlt;
    logic        rw;
    logic [3:0]  dest;
    logic [15:0] wdata;
    logic        men;
    logic        mwr;
    logic [15:0] maddr;
    logic [15:0] mdin;
  } exp_t;

  exp_t sb[$];

  cpu_single_cycle #(.IMEM_FILE(""), .MEM_DEPTH(65536)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .hlt(hlt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.memory1c_instr_instance.mem[i] = 16'hF000;
  endtask

  task automatic push_step(input logic [15:0] p, input logic [15:0] w, input logic rw,
                           input logic [3:0] d, input logic [15:0] wd, input logic men,
                           input logic mwr, input logic [15:0] ma, input logic [15:0] md);
    exp_t e;
    dut.memory1c_instr_instance.mem[p[15:1]] = w;
    e.pc = p; e.inst = w; e.hlt = (w[15:12] == 4'hF); e.rw = rw; e.dest = d; e.wdata = wd;
    e.men = men; e.mwr = mwr; e.maddr = ma; e.mdin = md;
    sb.push_back(e);
  endtask

  task automatic alu(input logic [15:0] p, input logic [15:0] w, input logic [3:0] d,
                     input logic [15:0] wd);
    push_step(p, w, 1'b1, d, wd, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic ctl(input logic [15:0] p, input logic [15:0] w);
    push_step(p, w, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cycle();
    exp_t e;
    e = sb.pop_front();
    chk("pc", pc, e.pc);
    chk("instruction", dut.instruction, e.inst);
    chk("hlt", {15'd0, hlt}, {15'd0, e.hlt});
    chk("reg_write", {15'd0, dut.reg_write}, {15'd0, e.rw});
    if (e.rw) begin
      chk("dest_reg", {12'd0, dut.dest_reg}, {12'd0, e.dest});
      chk("reg_write_data", dut.reg_write_data, e.wdata);
    end
    chk("mem_enable", {15'd0, dut.memory1c_data_instance.enable}, {15'd0, e.men});
    chk("mem_wr", {15'd0, dut.memory1c_data_instance.wr}, {15'd0, e.mwr});
    if (e.men) chk("mem_addr", dut.memory1c_data_instance.addr, e.maddr);
    if (e.mwr) chk("mem_data_in", dut.memory1c_data_instance.data_in, e.mdin);
  endtask

  task automatic prog1();
    alu(16'h0000, 16'hA1FF, 4'd1, 16'h00FF);
    alu(16'h0002, 16'hB17F, 4'd1, 16'h7FFF);
    alu(16'h0004, 16'hA201, 4'd2, 16'h0001);
    alu(16'h0006, 16'h0312, 4'd3, 16'h7FFF);
    alu(16'h0008, 16'h1433, 4'd4, 16'h0000);
    push_step(16'h000A, 16'h9302, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h7FFF);
    push_step(16'h000C, 16'h8502, 1'b1, 4'd5, 16'h7FFF, 1'b1, 1'b0, 16'h0004, 16'h0000);
    alu(16'h000E, 16'hA712, 4'd7, 16'h0012);
    ctl(16'h0010, 16'hC203);
    ctl(16'h0018, 16'hC005);
    ctl(16'h001A, 16'hCE02);
    alu(16'h0020, 16'hE600, 4'd6, 16'h0022);
    alu(16'h0022, 16'hA62A, 4'd6, 16'h002A);
    ctl(16'h0024, 16'hDE60);
    alu(16'h002A, 16'h0012, 4'd0, 16'h7FFF);
    alu(16'h002C, 16'h2801, 4'd8, 16'h7FFF);
    alu(16'h002E, 16'h1921, 4'd9, 16'h8002);
    ctl(16'h0030, 16'hF000);
  endtask

  task automatic prog2();
    alu(16'h0000, 16'hA180, 4'd1, 16'h0080);
    alu(16'h0002, 16'hB180, 4'd1, 16'h8080);
    alu(16'h0004, 16'h5214, 4'd2, 16'hF808);
    alu(16'h0006, 16'h6314, 4'd3, 16'h0808);
    alu(16'h0008, 16'h4411, 4'd4, 16'h0100);
    alu(16'h000A, 16'hA577, 4'd5, 16'h0077);
    alu(16'h000C, 16'hB578, 4'd5, 16'h7877);
    alu(16'h000E, 16'h7655, 4'd6, 16'h7877);
    alu(16'h0010, 16'h7754, 4'd7, 16'h7977);
    alu(16'h0012, 16'h3815, 4'd8, 16'hFFEF);
    alu(16'h0014, 16'h1915, 4'd9, 16'h8000);
    ctl(16'h0016, 16'hCC01);
    ctl(16'h001A, 16'hC601);
    push_step(16'h001E, 16'h990F, 1'b0, 4'd9, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'h8000);
    push_step(16'h0020, 16'h8A0F, 1'b1, 4'd10, 16'h8000, 1'b1, 1'b0, 16'hFFFE, 16'h0000);
    ctl(16'h0022, 16'hF000);
  endtask

  initial begin
    rst_n = 1'b1;
    clear_imem();
    prog1();
    repeat (2) begin
      @(negedge clk);
      chk("reset_pc", pc, 16'h0000);
      chk("reset_hlt", {15'd0, hlt}, 16'h0000);
    end
    rst_n = 1'b0;
    #1;
    while (sb.size() > 0) begin
      check_cycle();
      step();
    end
    repeat (3) begin
      chk("halted_pc", pc, 16'h0030);
      chk("halted_hlt", {15'd0, hlt}, 16'h0001);
      chk("halted_reg_write", {15'd0, dut.reg_write}, 16'h0000);
      chk("halted_mem_enable", {15'd0, dut.memory1c_data_instance.enable}, 16'h0000);
      step();
    end

    // asynchronous reset out of halt, then a store interrupted by reset
    rst_n = 1'b1;
    #1;
    chk("async_reset_pc", pc, 16'h0000);
    clear_imem();
    dut.memory1c_data_instance.mem[16'h7FFF] = 16'h1234;
    prog2();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    repeat (13) begin
      check_cycle();
      step();
    end
    check_cycle();
    rst_n = 1'b1;
    #1;
    chk("midrun_reset_pc", pc, 16'h0000);
    @(posedge clk);
    #1;
    chk("store_cancelled", dut.memory1c_data_instance.mem[16'h7FFF], 16'h1234);
    @(negedge clk);
    sb.delete();
    prog2();
    rst_n = 1'b0;
    #1;
    repeat (16) begin
      check_cycle();
      step();
    end
    chk("halt2_pc", pc, 16'h0022);
    chk("halt2_hlt", {15'd0, hlt}, 16'h0001);
    chk("store_committed", dut.memory1c_data_instance.mem[16'h7FFF], 16'h8000);
    chk("r10_loaded", dut.regs[10], 16'h8000);
    chk("r0_zero", dut.regs[0], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
